// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream frame arbiter and frame FIFO.
package axis_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } arb_state_e;

    // Index width for n ports, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Packed beat word layout, LSB first: data, keep, last, id, dest, user.
    // The frame FIFO stores the same word, so both sides share these offsets.
    function automatic int keep_off(input int dw);
        return dw;
    endfunction

    function automatic int last_off(input int dw, input int kw);
        return dw + kw;
    endfunction

    function automatic int id_off(input int dw, input int kw);
        return dw + kw + 1;
    endfunction

    function automatic int dest_off(input int dw, input int kw, input int iw);
        return dw + kw + 1 + iw;
    endfunction

    function automatic int user_off(input int dw, input int kw, input int iw, input int dsw);
        return dw + kw + 1 + iw + dsw;
    endfunction

    function automatic int word_width(input int dw, input int kw, input int iw, input int dsw,
                                      input int uw);
        return dw + kw + 1 + iw + dsw + uw;
    endfunction

endpackage

// File: rtl/rr_priority_arbiter.sv
// Combinational round-robin pick: first requester after last_ptr, with wrap.
module rr_priority_arbiter
    import axis_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]              req,
    input  logic [idx_width(N)-1:0]   last_ptr,
    output logic [idx_width(N)-1:0]   grant_idx,
    output logic                      grant_valid
);

    localparam int IW = idx_width(N);

    int j;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant_idx   = '0;
        grant_valid = |req;
        j           = 0;
        for (int k = N; k >= 1; k--) begin
            j = (int'(last_ptr) + k) % N;
            if (req[IW'(j)]) grant_idx = IW'(j);
        end
    end

endmodule

// File: rtl/axis_frame_arb_mux.sv
// Frame-aware round-robin AXI-Stream mux with a registered skid output stage.
module axis_frame_arb_mux
    import axis_pkg::*;
#(
    parameter int S_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_WIDTH  = 1
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic [S_COUNT*DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic [S_COUNT-1:0]               s_axis_tvalid,
    output logic [S_COUNT-1:0]               s_axis_tready,
    input  logic [S_COUNT-1:0]               s_axis_tlast,
    input  logic [S_COUNT*ID_WIDTH-1:0]      s_axis_tid,
    input  logic [S_COUNT*DEST_WIDTH-1:0]    s_axis_tdest,
    input  logic [S_COUNT*USER_WIDTH-1:0]    s_axis_tuser,

    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic [ID_WIDTH-1:0]              m_axis_tid,
    output logic [DEST_WIDTH-1:0]            m_axis_tdest,
    output logic [USER_WIDTH-1:0]            m_axis_tuser,

    output logic [idx_width(S_COUNT)-1:0]    grant_index,
    output logic                             grant_active
);

    localparam int IW = idx_width(S_COUNT);
    localparam int KO = keep_off(DATA_WIDTH);
    localparam int LO = last_off(DATA_WIDTH, KEEP_WIDTH);
    localparam int IO = id_off(DATA_WIDTH, KEEP_WIDTH);
    localparam int DO = dest_off(DATA_WIDTH, KEEP_WIDTH, ID_WIDTH);
    localparam int UO = user_off(DATA_WIDTH, KEEP_WIDTH, ID_WIDTH, DEST_WIDTH);
    localparam int WW = word_width(DATA_WIDTH, KEEP_WIDTH, ID_WIDTH, DEST_WIDTH, USER_WIDTH);

    arb_state_e      state;
    logic [IW-1:0]   last_ptr;
    logic [IW-1:0]   arb_idx;
    logic            arb_valid;

    logic [WW-1:0]   in_word;
    logic            sel_valid;
    logic            in_accept;
    logic            accept_last;

    logic            ready_int_reg;
    logic            ready_early;
    logic [WW-1:0]   out_word;
    logic            out_valid;
    logic [WW-1:0]   temp_word;
    logic            temp_valid;

    rr_priority_arbiter #(.N(S_COUNT)) u_arb (
        .req         (s_axis_tvalid),
        .last_ptr    (last_ptr),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // Select the granted port's beat and pack it into one word.
    always_comb begin
        in_word   = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (grant_index == IW'(i)) begin
                in_word[0 +: DATA_WIDTH]  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                in_word[KO +: KEEP_WIDTH] = KEEP_ENABLE ? s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH]
                                                        : {KEEP_WIDTH{1'b1}};
                in_word[LO]               = s_axis_tlast[i];
                in_word[IO +: ID_WIDTH]   = s_axis_tid[i*ID_WIDTH +: ID_WIDTH];
                in_word[DO +: DEST_WIDTH] = s_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH];
                in_word[UO +: USER_WIDTH] = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
                sel_valid                 = s_axis_tvalid[i];
            end
        end
    end

    // Only the granted port ever sees ready, and only from the registered ready.
    always_comb begin
        s_axis_tready = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            s_axis_tready[i] = grant_active && (grant_index == IW'(i)) && ready_int_reg;
        end
    end

    assign in_accept   = grant_active && sel_valid && ready_int_reg;
    assign accept_last = in_accept && in_word[LO];

    // Keep accepting next cycle unless this cycle's beat would fill the temp register.
    assign ready_early = m_axis_tready || (!temp_valid && (!out_valid || !in_accept));

    // Grant FSM: arbitrate in IDLE, hold the grant until the tlast beat is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            grant_active <= 1'b0;
            grant_index  <= '0;
            last_ptr     <= IW'(S_COUNT - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        state        <= ST_ACTIVE;
                        grant_active <= 1'b1;
                        grant_index  <= arb_idx;
                        last_ptr     <= arb_idx;
                    end
                end
                ST_ACTIVE: begin
                    if (accept_last) begin
                        state        <= ST_IDLE;
                        grant_active <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    grant_active <= 1'b0;
                end
            endcase
        end
    end

    // Two-register skid: a beat goes straight to the output when it is free,
    // otherwise parks in temp and is promoted when the sink drains the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_int_reg <= 1'b0;
            out_valid     <= 1'b0;
            temp_valid    <= 1'b0;
            out_word      <= '0;
            temp_word     <= '0;
        end else begin
            ready_int_reg <= ready_early;
            if (ready_int_reg) begin
                if (m_axis_tready || !out_valid) begin
                    out_word  <= in_word;
                    out_valid <= in_accept;
                end else begin
                    temp_word  <= in_word;
                    temp_valid <= in_accept;
                end
            end else if (m_axis_tready) begin
                out_word   <= temp_word;
                out_valid  <= temp_valid;
                temp_valid <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = out_valid;
    assign m_axis_tdata  = out_word[0 +: DATA_WIDTH];
    assign m_axis_tkeep  = out_word[KO +: KEEP_WIDTH];
    assign m_axis_tlast  = out_word[LO];
    assign m_axis_tid    = out_word[IO +: ID_WIDTH];
    assign m_axis_tdest  = out_word[DO +: DEST_WIDTH];
    assign m_axis_tuser  = out_word[UO +: USER_WIDTH];

endmodule

// File: doc/axis_frame_arb_mux.md
Name: axis_frame_arb_mux

Overview:
- Frame-aware round-robin arbiter/multiplexer that shares one AXI-Stream sink, typically a frame FIFO input, among S_COUNT AXI-Stream sources.
- A grant is held from a frame's first beat until its tlast beat is accepted, so frames are never interleaved.
- Output has a registered skid stage for full throughput and clean timing into the FIFO.

Parameters:
S_COUNT, 4, number of source ports (2..16)
DATA_WIDTH, 8, tdata width per port
KEEP_ENABLE, (DATA_WIDTH>8), carry tkeep
KEEP_WIDTH, DATA_WIDTH/8, tkeep width
ID_WIDTH, 8, tid width
DEST_WIDTH, 8, tdest width
USER_WIDTH, 1, tuser width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
s_axis_tdata  in  S_COUNT*DATA_WIDTH  concatenated sources, port i at [i*DATA_WIDTH +: DATA_WIDTH]
s_axis_tkeep  in  S_COUNT*KEEP_WIDTH  concatenated tkeep
s_axis_tvalid  in  S_COUNT  per-port valid
s_axis_tready  out  S_COUNT  per-port ready
s_axis_tlast  in  S_COUNT  per-port last
s_axis_tid  in  S_COUNT*ID_WIDTH  concatenated tid
s_axis_tdest  in  S_COUNT*DEST_WIDTH  concatenated tdest
s_axis_tuser  in  S_COUNT*USER_WIDTH  concatenated tuser
m_axis_tdata/tkeep/tid/tdest/tuser  out  per widths above  muxed beat
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  output last
grant_index  out  $clog2(S_COUNT) (min 1)  currently granted port
grant_active  out  1  a frame is in progress

Behaviour:
- States: IDLE, ACTIVE.
- Reset: state IDLE, grant_active 0, grant_index 0, last-grant pointer S_COUNT-1 (port 0 wins first), s_axis_tready all 0, m_axis_tvalid 0, skid register empty.
- IDLE: all s_axis_tready 0. If any tvalid, pick the first asserted port scanning from (last+1) mod S_COUNT upward with wrap. Next cycle: grant_index=pick, grant_active=1, state ACTIVE, last-grant pointer=pick. Arbitration latency 1 cycle.
- ACTIVE: s_axis_tready[grant_index]=ready_int, all other readies 0.
- ready_int = m_axis_tready || !m_axis_tvalid || skid empty, registered so it depends on no combinational m_axis_tready path. Use the standard two-register skid: output reg plus temp reg, and no beat is ever lost or duplicated.
- Accepted beat (tvalid&&tready on granted port) appears on m_axis at the earliest the following cycle. Source-to-output latency 1 cycle when unstalled. Sustained throughput 1 beat/cycle.
- Accepted beat with tlast=1: next state IDLE, grant_active 0. One idle bubble cycle between frames, including back-to-back frames from the same port. Re-arbitration happens in that IDLE cycle.
- Single-beat frame (tlast on first beat): one beat, then IDLE.
- Granted source drops tvalid mid-frame: grant is held indefinitely, with no timeout. Other sources stall.
- Non-granted sources never see tready=1.
- Output backpressure: once skid full, ready_int=0 until m_axis_tready. Data order is preserved.
- Output fields tdata/tkeep/tlast/tid/tdest/tuser travel together as one registered word. tkeep is forced all-ones when !KEEP_ENABLE.
- rst asserted mid-frame: next cycle all state returns to reset values and in-flight skid data is discarded. Sources must also be reset; partial frames are not completed.
- Round-robin fairness: with all S_COUNT ports continuously requesting, grants cycle 0,1,2,…,S_COUNT-1,0.

Decomposition:
- Shared package axis_pkg holds:
  - the state enum (IDLE/ACTIVE);
  - a function computing the index width (max(1,$clog2(n)));
  - the packed-field offset localparams (KEEP/LAST/ID/DEST/USER offsets), reused with the FIFO.
- One natural sub-module: rr_priority_arbiter. Parameter N; inputs req[N], last_ptr, output grant_idx, grant_valid. Purely combinational rotate-and-priority-encode, independently testable.

Test Plan:
- Only port 2 sends a 3-beat frame, data 0x11,0x22,0x33 with tlast on 0x33, m_axis_tready=1 -> grant_index=2 one cycle after tvalid; m_axis shows 0x11,0x22,0x33 on consecutive cycles with tlast on 0x33; grant_active falls after.
- All 4 ports continuously send 1-beat frames (data = port number) -> output sequence 0,1,2,3,0,1,… with exactly one bubble between frames.
- Port 0 sends 4-beat frame while port 1 requests; m_axis_tready toggles 1,0,1,0 -> port 0's 4 beats are output contiguous and in order, with no port 1 beat interleaved, then port 1 granted.
- m_axis_tready=0 for 5 cycles mid-frame -> at most 2 beats buffered; s_axis_tready[grant] low by the cycle after skid full; no beat lost or duplicated on release.
- Granted port 3 deasserts tvalid for 10 cycles mid-frame while port 0 requests -> grant stays 3 and port 0 tready stays 0; port 3 completes first.
- rst pulsed for 1 cycle mid-frame with skid holding data -> next cycle m_axis_tvalid=0, all s_axis_tready=0, grant_active=0; the following arbitration grants port 0 first.
